gf_poly_scale_seq: RTL and testbench

Sequential polynomial scaler: multiplies every coefficient of a flat-packed GF(2^SIZE) polynomial by one scalar, one coefficient per clock, through a single shared GF multiplier. It is the area-reduced, handshaked counterpart of the combinational polynomial scaler. It sits between the syndrome/locator stages of the RS decoder, which feed it work through valid/ready.

---
 rtl/gf_poly_scale_seq.sv | 136 +++++++++++++
 tb/tb_gf_poly_scale_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gf_poly_scale_seq.sv
// Sequential GF(2^SIZE) polynomial scaler: one coefficient per clock through a shared multiplier.
// Optional macro GF_SCALE_TRIVIAL_BYPASS_EN short-circuits scalar 0/1 straight to DONE.
module gf_poly_scale_seq #(
    parameter int              m         = 255,
    parameter int              SIZE      = $clog2(m),
    parameter int              n         = 2,
    parameter int              flat_size = (n + 1) * SIZE,
    parameter logic [SIZE:0]   PRIM      = 9'h11D
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [flat_size-1:0] flat_p,
    input  logic [SIZE-1:0]      scalar,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [flat_size-1:0] flat_scaled_p,
    output logic                 busy
);

    localparam int IDX_W = (n + 1 > 1) ? $clog2(n + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [flat_size-1:0]   res_q, res_d;
    logic [flat_size-1:0]   coef_q;
    logic [SIZE-1:0]        scalar_q;
    logic [SIZE-1:0]        cur_coef;
    logic [SIZE-1:0]        prod;

    // Carry-less product followed by reduction of the high bits modulo PRIM.
    function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                               input logic [SIZE-1:0] b);
        logic [2*SIZE-2:0] p;
        logic [2*SIZE-2:0] a_ext;
        logic [2*SIZE-2:0] poly_ext;
        p        = '0;
        a_ext    = (2*SIZE-1)'(a);
        poly_ext = (2*SIZE-1)'(PRIM);
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) begin
                p = p ^ (a_ext << i);
            end
        end
        for (int i = 2*SIZE-2; i >= SIZE; i--) begin
            if (p[i]) begin
                p = p ^ (poly_ext << (i - SIZE));
            end
        end
        return p[SIZE-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    // Operand capture is datapath only; it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            coef_q   <= flat_p;
            scalar_q <= scalar;
        end
    end

    always_comb begin
        cur_coef = '0;
        for (int i = 0; i <= n; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_coef = coef_q[i*SIZE +: SIZE];
            end
        end
        prod = gf_mul(cur_coef, scalar_q);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    idx_d   = '0;
                    state_d = BUSY;
`ifdef GF_SCALE_TRIVIAL_BYPASS_EN
                    if (scalar == '0) begin
                        res_d   = '0;
                        state_d = DONE;
                    end else if (scalar == SIZE'(1)) begin
                        res_d   = flat_p;
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                for (int i = 0; i <= n; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        res_d[i*SIZE +: SIZE] = prod;
                    end
                end
                if (idx_q == IDX_W'(n)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign busy          = (state_q == BUSY);
    assign flat_scaled_p = res_q;

endmodule

// File: tb/tb_gf_poly_scale_seq.sv
// Scoreboard bench for gf_poly_scale_seq at default parameters (GF(2^8), n = 2).
module tb_gf_poly_scale_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] flat_p;
    logic [7:0]  scalar;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] flat_scaled_p;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [23:0] exp_q[$];

`ifdef GF_SCALE_TRIVIAL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    gf_poly_scale_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flat_p        (flat_p),
        .scalar        (scalar),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .flat_scaled_p (flat_scaled_p),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference multiply: peasant algorithm with xtime reduction by 0x11D.
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x, y;
        r = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) r = r ^ x;
            y = y >> 1;
            x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [23:0] scale_ref(input logic [23:0] p, input logic [7:0] s);
        return {gf_ref(p[23:16], s), gf_ref(p[15:8], s), gf_ref(p[7:0], s)};
    endfunction

    // Presents a request, waits for acceptance, pushes its expected result.
    // Returns at the falling edge right after the accepting edge.
    task automatic accept(input logic [23:0] f, input logic [7:0] s,
                          input logic [23:0] expv, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1; flat_p = f; scalar = s;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            exp_q.push_back(expv);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Counts edges since the accepting edge (that edge counts as 1).
    task automatic wait_out(output int cycles, output bit ok);
        cycles = 1;
        while (!out_valid && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
        ok = out_valid;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic pop_expected(output logic [23:0] e);
        e = 24'hxxxxxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flat_p = '0; scalar = '0;
        repeat (3) @(negedge clk);
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (flat_scaled_p !== 24'h0) begin tests_failed++; $display("FAIL reset_result got %h want 000000", flat_scaled_p); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic run_one(input string name, input logic [23:0] f, input logic [7:0] s,
                           input logic [23:0] expv, input int exp_lat, input logic exp_busy);
        bit ok; int lat; logic [23:0] e;
        accept(f, s, expv, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL %s_accept timed out", name); end
        tests_run++; if (busy !== exp_busy) begin tests_failed++; $display("FAIL %s_busy got %b want %b", name, busy, exp_busy); end
        wait_out(lat, ok);
        tests_run++; if (lat !== exp_lat) begin tests_failed++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
        pop_expected(e);
        tests_run++; if (flat_scaled_p !== e) begin tests_failed++; $display("FAIL %s_value got %h want %h", name, flat_scaled_p, e); end
        handoff();
    endtask

    task automatic test_basic();
        run_one("basic", 24'h020407, 8'h05, 24'h0A141B, 4, 1'b1);
    endtask

    task automatic test_reduction();
        run_one("reduction", 24'h800102, 8'h02, 24'h1D0204, 4, 1'b1);
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [23:0] e, held;
        accept(24'h3C5A77, 8'h1F, scale_ref(24'h3C5A77, 8'h1F), ok);
        wait_out(lat, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL bp_out_valid timed out"); end
        pop_expected(e);
        held = flat_scaled_p;
        tests_run++; if (held !== e) begin tests_failed++; $display("FAIL bp_value got %h want %h", held, e); end
        in_valid = 1'b1; flat_p = 24'h112233; scalar = 8'h09;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || flat_scaled_p !== held) begin
                tests_failed++;
                $display("FAIL bp_hold cyc%0d got vld=%b rdy=%b res=%h want 1 0 %h", i, out_valid, in_ready, flat_scaled_p, held);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_after_handoff got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        run_one("bp_next", 24'h112233, 8'h09, scale_ref(24'h112233, 8'h09), 4, 1'b1);
    endtask

    task automatic test_reset_mid_busy();
        bit ok; bit seen;
        accept(24'h445566, 8'h07, scale_ref(24'h445566, 8'h07), ok);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || flat_scaled_p !== 24'h0) begin
            tests_failed++;
            $display("FAIL midrst_outputs got rdy=%b vld=%b busy=%b res=%h want 1 0 0 000000", in_ready, out_valid, busy, flat_scaled_p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_valid got %b want 0", seen); end
        run_one("midrst_next", 24'h010101, 8'h03, 24'h030303, 4, 1'b1);
    endtask

    task automatic test_trivial();
        int lat_exp;
        lat_exp = BYPASS ? 1 : 4;
        run_one("scalar0", 24'hA5C3E7, 8'h00, 24'h000000, lat_exp, !BYPASS);
        run_one("scalar1", 24'hA5C3E7, 8'h01, 24'hA5C3E7, lat_exp, !BYPASS);
    endtask

    task automatic test_back_to_back();
        logic [23:0] f; logic [7:0] s;
        for (int i = 0; i < 4; i++) begin
            f = 24'($urandom);
            s = 8'($urandom_range(2, 255));
            run_one("b2b", f, s, scale_ref(f, s), 4, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reduction();
        test_backpressure();
        test_reset_mid_busy();
        test_trivial();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
